digest_serializer: RTL and testbench

DIGEST_SERIALIZER -- requirements
Module: digest_serializer

---
 rtl/digest_serializer_pkg.sv | 18 +
 rtl/digest_serializer_if.sv | 44 ++++
 rtl/digest_serializer.sv | 129 ++++++++++++
 tb/tb_digest_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/digest_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digest_serializer_pkg
// Purpose  : Shared sponge-construction constants for the digest serializer
//            and its bus interface.
// Contents : STATE_W          - width of the permutation state
//            RATE_W           - sponge rate in bits
//            DIGEST_W_DEFAULT - default digest width (64-bit words x 8)
// Revision : 1.0 - initial release
// ============================================================================
package digest_serializer_pkg;

  localparam int STATE_W          = 1600;
  localparam int RATE_W           = 576;
  localparam int DIGEST_W_DEFAULT = 512;

endpackage : digest_serializer_pkg
`default_nettype wire

// File: rtl/digest_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : digest_serializer_if
// Purpose  : Bundles the permutation-side inputs and the word-stream output
//            of the digest serializer.
// Signals  : state_in      - permutation state (digest in the top bits)
//            state_ready   - permutation output valid (level)
//            last_absorbed - pulse: final padded block accepted
//            dout          - current digest word, MS word first
//            dout_valid    - dout holds a valid word
//            dout_ready    - sink accepts dout this cycle
//            dout_last     - final word of the digest
//            busy          - serializer armed or streaming
//            overrun       - sticky: capture attempted while streaming
// Modports : master - the serializer; slave - the surrounding environment
// Revision : 1.0 - initial release
// ============================================================================
interface digest_serializer_if #(
  parameter int WORD_W = 64
);
  import digest_serializer_pkg::*;

  logic [STATE_W-1:0] state_in;
  logic               state_ready;
  logic               last_absorbed;
  logic [WORD_W-1:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;
  logic               busy;
  logic               overrun;

  modport master (
    input  state_in, state_ready, last_absorbed, dout_ready,
    output dout, dout_valid, dout_last, busy, overrun
  );

  modport slave (
    output state_in, state_ready, last_absorbed, dout_ready,
    input  dout, dout_valid, dout_last, busy, overrun
  );

endinterface : digest_serializer_if
`default_nettype wire

// File: rtl/digest_serializer.sv
`default_nettype none
// ============================================================================
// Module   : digest_serializer
// Purpose  : Captures the digest from the permutation state once the final
//            block has been absorbed and streams it out as NUM_WORDS words of
//            WORD_W bits, most significant word first, with valid/ready flow
//            control.
// Ports    : clk   - single clock, rising edge
//            reset - asynchronous, active-high
//            bus   - digest_serializer_if.master (see interface for signals)
// Revision : 1.0 - initial release
// ============================================================================
module digest_serializer
  import digest_serializer_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 8
) (
  input  logic                clk,
  input  logic                reset,
  digest_serializer_if.master bus
);

  localparam int DIGEST_W = WORD_W * NUM_WORDS;
  localparam int CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_armed;
  logic                r_ready_d;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIGEST_W-1:0] r_shift;

  logic w_capture;
  logic w_load;
  logic w_xfer;
  logic w_is_last;
  logic w_sending;

  // A capture needs a fresh rising edge of state_ready while armed; a level
  // held high never re-triggers.
  assign w_capture = bus.state_ready & ~r_ready_d & r_armed;
  // Only an idle serializer acts on a capture; in SEND it only flags overrun.
  assign w_load    = w_capture & (r_state == S_IDLE);
  assign w_sending = (r_state == S_SEND);
  assign w_xfer    = w_sending & bus.dout_ready;
  assign w_is_last = (r_cnt == C_LAST_IDX);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_next = S_SEND;
      S_SEND:  if (w_xfer && w_is_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: arm flag, edge detector, shift register, word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed   <= 1'b0;
      r_ready_d <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
    end else begin
      r_ready_d <= bus.state_ready;

      // A last_absorbed pulse re-arms even on the edge that consumes the
      // previous arm, so it takes priority over the clear.
      if (bus.last_absorbed) begin
        r_armed <= 1'b1;
      end else if (w_load) begin
        r_armed <= 1'b0;
      end

      if (w_capture && w_sending) begin
        r_overrun <= 1'b1;
      end

      if (w_load) begin
        r_shift <= bus.state_in[STATE_W-1 -: DIGEST_W];
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_shift <= r_shift << WORD_W;
        r_cnt   <= w_is_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // The state bits below the digest are never consumed.
  generate
    if (DIGEST_W < STATE_W) begin : g_unused_low
      logic w_unused_low;
      assign w_unused_low = ^bus.state_in[STATE_W-DIGEST_W-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state, so reset clears them at once
  // --------------------------------------------------------------------------
  assign bus.dout_valid = w_sending;
  assign bus.dout       = w_sending ? r_shift[DIGEST_W-1 -: WORD_W] : '0;
  assign bus.dout_last  = w_sending & w_is_last;
  assign bus.busy       = r_armed | w_sending;
  assign bus.overrun    = r_overrun;

endmodule : digest_serializer
`default_nettype wire

// File: tb/tb_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_digest_serializer
// Purpose  : Directed self-checking bench for digest_serializer
//            (64-bit words, 8 words per digest).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digest_serializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  digest_serializer_if #(.WORD_W(64)) bus ();

  digest_serializer #(
    .WORD_W    (64),
    .NUM_WORDS (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [63:0] got      [8];
  logic        got_last [8];
  int          n;
  int          cyc;
  int          unstable;

  // Digest word i (0 = most significant) is base+i+1; bits below the digest
  // carry a filler pattern that must never appear on dout.
  function automatic logic [1599:0] mk_state(input logic [63:0] base);
    logic [1599:0] s;
    s = {25{64'hA5A5_5A5A_0F0F_F0F0}};
    for (int i = 0; i < 8; i++) s[1599-64*i -: 64] = base + 64'(i + 1);
    return s;
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] base, input int i);
    return base + 64'(i + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    bus.last_absorbed = 1'b1;
    step();
    bus.last_absorbed = 1'b0;
  endtask

  // Records transfers into got[] from index start until 8 words are taken or
  // the budget expires; dout_ready follows pat[cyc%4]. Counts any change of
  // a stalled word in 'unstable'.
  task automatic collect(input logic [3:0] pat, input int start, input int budget);
    logic [63:0] held;
    logic        held_last;
    logic        held_v;
    n = start; cyc = 0; unstable = 0;
    held = '0; held_last = 1'b0; held_v = 1'b0;
    while (n < 8 && cyc < budget) begin
      bus.dout_ready = pat[cyc % 4];
      if (held_v && (bus.dout_valid !== 1'b1 || bus.dout !== held || bus.dout_last !== held_last))
        unstable++;
      held_v = 1'b0;
      if (bus.dout_valid === 1'b1) begin
        if (bus.dout_ready) begin
          got[n] = bus.dout; got_last[n] = bus.dout_last; n++;
        end else begin
          held = bus.dout; held_last = bus.dout_last; held_v = 1'b1;
        end
      end
      step();
      cyc++;
    end
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.state_in = '0; bus.state_ready = 1'b0; bus.last_absorbed = 1'b0; bus.dout_ready = 1'b0;
    step(); step();
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
    tests++; if (bus.dout !== 64'h0) begin fails++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
    tests++; if (bus.dout_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", bus.dout_last); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bus.dout_ready = 1'b1;
    arm();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_armed_busy: got %b want 1", bus.busy); end
    bus.state_in = mk_state(64'h0); bus.state_ready = 1'b1;
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL basic_pre_valid: got %b want 0", bus.dout_valid); end
    step();
    tests++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b want 1", bus.dout_valid); end
    tests++; if (bus.dout !== 64'h1) begin fails++; $display("FAIL basic_first: got %h want 1", bus.dout); end
    collect(4'b1111, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL basic_count: got %0d want 8", n); end
    tests++; if (cyc !== 8) begin fails++; $display("FAIL basic_cycles: got %0d want 8", cyc); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h0, i)) begin fails++; $display("FAIL basic_word%0d: got %h want %h", i, got[i], exp_word(64'h0, i)); end
      tests++; if (got_last[i] !== (i == 7)) begin fails++; $display("FAIL basic_last%0d: got %b want %b", i, got_last[i], (i == 7)); end
    end
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL basic_end_valid: got %b want 0", bus.dout_valid); end
    tests++; if (bus.dout !== 64'h0) begin fails++; $display("FAIL basic_end_dout: got %h want 0", bus.dout); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_end_busy: got %b want 0", bus.busy); end
    bus.state_ready = 1'b0;
    step();
  endtask

  task automatic test_stall();
    arm();
    bus.state_in = mk_state(64'h20); bus.state_ready = 1'b1;
    step();
    collect(4'b1001, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL stall_count: got %0d want 8", n); end
    tests++; if (cyc !== 16) begin fails++; $display("FAIL stall_cycles: got %0d want 16", cyc); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h20, i)) begin fails++; $display("FAIL stall_word%0d: got %h want %h", i, got[i], exp_word(64'h20, i)); end
      tests++; if (got_last[i] !== (i == 7)) begin fails++; $display("FAIL stall_last%0d: got %b want %b", i, got_last[i], (i == 7)); end
    end
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL stall_end_valid: got %b want 0", bus.dout_valid); end
    bus.state_ready = 1'b0;
    step();
  endtask

  task automatic test_unarmed();
    int act;
    act = 0;
    for (int k = 0; k < 3; k++) begin
      bus.state_in = mk_state(64'h10 * 64'(k + 1)); bus.state_ready = 1'b1;
      repeat (2) begin step(); if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) act++; end
      bus.state_ready = 1'b0;
      repeat (2) begin step(); if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) act++; end
    end
    tests++; if (act !== 0) begin fails++; $display("FAIL unarmed_activity: got %0d active cycles want 0", act); end
    arm();
    bus.state_in = mk_state(64'h40); bus.state_ready = 1'b1;
    step();
    tests++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL unarmed_fourth_valid: got %b want 1", bus.dout_valid); end
    collect(4'b1111, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL unarmed_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h40, i)) begin fails++; $display("FAIL unarmed_word%0d: got %h want %h", i, got[i], exp_word(64'h40, i)); end
    end
    bus.state_ready = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    arm();
    bus.state_in = mk_state(64'h100); bus.state_ready = 1'b1;
    step();
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_initial: got %b want 0", bus.overrun); end
    got[0] = bus.dout; got_last[0] = bus.dout_last;
    bus.state_ready = 1'b0; bus.last_absorbed = 1'b1;
    step();
    got[1] = bus.dout; got_last[1] = bus.dout_last;
    bus.last_absorbed = 1'b0;
    bus.state_in = mk_state(64'h200); bus.state_ready = 1'b1;
    step();
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
    tests++; if (bus.dout !== exp_word(64'h100, 2)) begin fails++; $display("FAIL ovr_word2: got %h want %h", bus.dout, exp_word(64'h100, 2)); end
    collect(4'b1111, 2, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL ovr_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h100, i)) begin fails++; $display("FAIL ovr_word%0d: got %h want %h", i, got[i], exp_word(64'h100, i)); end
    end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ovr_busy_after: got %b want 1", bus.busy); end
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL ovr_end_valid: got %b want 0", bus.dout_valid); end
    bus.state_ready = 1'b0;
    step();
    bus.state_in = mk_state(64'h300); bus.state_ready = 1'b1;
    step();
    tests++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL ovr_next_valid: got %b want 1", bus.dout_valid); end
    collect(4'b1111, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL ovr_next_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h300, i)) begin fails++; $display("FAIL ovr_next_word%0d: got %h want %h", i, got[i], exp_word(64'h300, i)); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ovr_next_busy: got %b want 0", bus.busy); end
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    bus.state_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int act;
    arm();
    bus.state_in = mk_state(64'h400); bus.state_ready = 1'b1;
    step();
    repeat (4) step();
    tests++; if (bus.dout !== exp_word(64'h400, 4)) begin fails++; $display("FAIL rst_mid_word4: got %h want %h", bus.dout, exp_word(64'h400, 4)); end
    reset = 1'b1;
    #1;
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", bus.dout_valid); end
    tests++; if (bus.dout !== 64'h0) begin fails++; $display("FAIL rst_mid_dout: got %h want 0", bus.dout); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rst_mid_overrun: got %b want 0", bus.overrun); end
    step();
    reset = 1'b0;
    act = 0;
    repeat (6) begin step(); if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) act++; end
    tests++; if (act !== 0) begin fails++; $display("FAIL rst_mid_after: got %0d active cycles want 0", act); end
    bus.state_ready = 1'b0;
    step();
  endtask

  task automatic test_coincide();
    arm();
    bus.state_in = mk_state(64'h500); bus.state_ready = 1'b1; bus.last_absorbed = 1'b1;
    step();
    bus.last_absorbed = 1'b0;
    tests++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL coin_valid: got %b want 1", bus.dout_valid); end
    collect(4'b1111, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL coin_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h500, i)) begin fails++; $display("FAIL coin_word%0d: got %h want %h", i, got[i], exp_word(64'h500, i)); end
    end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL coin_rearmed: got %b want 1", bus.busy); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL coin_overrun: got %b want 0", bus.overrun); end
    bus.state_ready = 1'b0;
    step();
    bus.state_in = mk_state(64'h600); bus.state_ready = 1'b1;
    step();
    tests++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL coin_second_valid: got %b want 1", bus.dout_valid); end
    collect(4'b1111, 0, 40);
    tests++; if (n !== 8) begin fails++; $display("FAIL coin_second_count: got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got[i] !== exp_word(64'h600, i)) begin fails++; $display("FAIL coin_second_word%0d: got %h want %h", i, got[i], exp_word(64'h600, i)); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL coin_second_busy: got %b want 0", bus.busy); end
    bus.state_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_unarmed();
    test_overrun();
    test_reset_mid();
    test_coincide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule : tb_digest_serializer
`default_nettype wire
